// File: rtl/pot_filter_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | pot_filter_ctrl: averages two pot readings and maps them to filter controls |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module pot_filter_ctrl #(
  parameter int POT_W    = 10,
  parameter int OUT_W    = 2,
  parameter int AVG_LOG2 = 2,
  parameter int HYST     = 8,
  parameter int CUT_MAX  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [POT_W-1:0] P0,
  input  logic [POT_W-1:0] P1,
  output logic [OUT_W-1:0] filter_sel,
  output logic [OUT_W-1:0] cutoff,
  output logic             upd
);

  localparam int S     = POT_W - OUT_W;
  localparam int AW    = POT_W + AVG_LOG2;
  localparam int CW    = POT_W + 2;
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [OUT_W-1:0] CUT_LIM  = OUT_W'(CUT_MAX);

  localparam logic [1:0] ST_ACCUM  = 2'd0;
  localparam logic [1:0] ST_EVAL   = 2'd1;
  localparam logic [1:0] ST_UPDATE = 2'd2;

  logic [1:0]       state_q,  state_d;
  logic [AW-1:0]    acc0_q,   acc0_d;
  logic [AW-1:0]    acc1_q,   acc1_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [POT_W-1:0] avg0_q,   avg0_d;
  logic [POT_W-1:0] avg1_q,   avg1_d;
  logic [OUT_W-1:0] cur0_q,   cur0_d;
  logic [OUT_W-1:0] cur1_q,   cur1_d;
  logic [OUT_W-1:0] cut_q,    cut_d;
  logic             upd_q,    upd_d;

  logic w_hs;

  // Band thresholds are widened by two bits so edge+HYST and edge-HYST never wrap.
  function automatic logic [OUT_W-1:0] hyst_band(
    input logic [POT_W-1:0] avg,
    input logic [OUT_W-1:0] cur
  );
    logic [CW-1:0]    a;
    logic [CW-1:0]    base;
    logic [CW-1:0]    up_thr;
    logic [OUT_W-1:0] q;
    logic [OUT_W-1:0] res;
    a      = CW'(avg);
    base   = CW'(cur) << S;
    up_thr = base + (CW'(1) << S) + CW'(HYST);
    q      = OUT_W'(avg >> S);
    res    = cur;
    if (q > cur) begin
      if (a >= up_thr) begin
        res = q;
      end
    end else if (q < cur) begin
      if ((base >= CW'(HYST)) && (a < (base - CW'(HYST)))) begin
        res = q;
      end
    end
    return res;
  endfunction

  assign in_ready = (state_q == ST_ACCUM);
  assign w_hs     = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    acc0_d  = acc0_q;
    acc1_d  = acc1_q;
    cnt_d   = cnt_q;
    avg0_d  = avg0_q;
    avg1_d  = avg1_q;
    case (state_q)
      ST_ACCUM: begin
        if (w_hs) begin
          acc0_d = acc0_q + AW'(P0);
          acc1_d = acc1_q + AW'(P1);
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_d = ST_EVAL;
          end
        end
      end
      ST_EVAL: begin
        avg0_d  = POT_W'(acc0_q >> AVG_LOG2);
        avg1_d  = POT_W'(acc1_q >> AVG_LOG2);
        acc0_d  = '0;
        acc1_d  = '0;
        cnt_d   = '0;
        state_d = ST_UPDATE;
      end
      ST_UPDATE: begin
        state_d = ST_ACCUM;
      end
      default: begin
        state_d = ST_ACCUM;
      end
    endcase
  end

  // The clamp is applied after hysteresis so cur1 keeps tracking above CUT_MAX silently.
  always_comb begin
    cur0_d = cur0_q;
    cur1_d = cur1_q;
    cut_d  = cut_q;
    upd_d  = 1'b0;
    if (state_q == ST_UPDATE) begin
      cur0_d = hyst_band(avg0_q, cur0_q);
      cur1_d = hyst_band(avg1_q, cur1_q);
      cut_d  = (cur1_d > CUT_LIM) ? CUT_LIM : cur1_d;
      upd_d  = (cur0_d != cur0_q) || (cut_d != cut_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_ACCUM;
      acc0_q  <= '0;
      acc1_q  <= '0;
      cnt_q   <= '0;
      avg0_q  <= '0;
      avg1_q  <= '0;
      cur0_q  <= '0;
      cur1_q  <= '0;
      cut_q   <= '0;
      upd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc0_q  <= acc0_d;
      acc1_q  <= acc1_d;
      cnt_q   <= cnt_d;
      avg0_q  <= avg0_d;
      avg1_q  <= avg1_d;
      cur0_q  <= cur0_d;
      cur1_q  <= cur1_d;
      cut_q   <= cut_d;
      upd_q   <= upd_d;
    end
  end

  assign filter_sel = cur0_q;
  assign cutoff     = cut_q;
  assign upd        = upd_q;

endmodule
`default_nettype wire
